// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared message addresses and sequencer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package display_pkg;

  // Message select codes; the HEX message memory decodes the same values.
  localparam logic [1:0] ADDR_NIVEL   = 2'b00;
  localparam logic [1:0] ADDR_VENCEU  = 2'b01;
  localparam logic [1:0] ADDR_PERDEU  = 2'b10;
  localparam logic [1:0] ADDR_APAGADO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NIVEL = 2'd1,
    S_PISCA = 2'd2,
    S_FIXO  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/contador_pisca.sv
// ============================================================================
// contador_pisca : blink half-period timer, pulses tick on wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module contador_pisca #(
  parameter int BLINK_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW     = $clog2(BLINK_CYCLES) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(BLINK_CYCLES - 1);

  logic [CW-1:0] r_count;

  assign tick = enable && (r_count == C_LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_ctrl.sv
// ============================================================================
// display_ctrl : turns game events into a registered message select for the
//                6-digit HEX memory, blinking results before holding them.
// Rev 1.0
// ============================================================================
`default_nettype none

module display_ctrl #(
  parameter int BLINK_CYCLES = 4,
  parameter int NUM_PISCAS   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] nivel,
  input  logic       venceu,
  input  logic       perdeu,
  input  logic       limpa,
  output logic [1:0] displayAddr,
  output logic [1:0] modo,
  output logic       ocupado,
  output logic       fim_msg
);

  import display_pkg::*;

  localparam int            PW          = $clog2(NUM_PISCAS) + 1;
  localparam logic [PW-1:0] C_PAIR_LAST = PW'(NUM_PISCAS - 1);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_res, w_res_nxt;
  logic [1:0]    r_modo, w_modo_nxt;
  logic          r_phase, w_phase_nxt;
  logic [PW-1:0] r_pares, w_pares_nxt;
  logic          w_tick, w_clear, w_enable;
  logic [1:0]    r_addr, w_addr_nxt;
  logic          r_ocupado, w_ocupado_nxt;
  logic          r_fim, w_fim_nxt;

  // Timer is held at zero outside PISCA so every entry starts a fresh count.
  assign w_enable = (r_state == S_PISCA);
  assign w_clear  = (w_state_nxt != S_PISCA);

  contador_pisca #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .enable(w_enable),
    .tick  (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_res   <= ADDR_VENCEU;
      r_modo  <= 2'b00;
      r_phase <= 1'b0;
      r_pares <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_res   <= w_res_nxt;
      r_modo  <= w_modo_nxt;
      r_phase <= w_phase_nxt;
      r_pares <= w_pares_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_res_nxt   = r_res;
    w_modo_nxt  = r_modo;
    case (r_state)
      S_IDLE: begin
        if (iniciar) begin
          w_state_nxt = S_NIVEL;
          w_modo_nxt  = nivel;
        end
      end
      S_NIVEL: begin
        if (limpa) begin
          w_state_nxt = S_IDLE;
        end else if (perdeu) begin
          w_state_nxt = S_PISCA;
          w_res_nxt   = ADDR_PERDEU;
        end else if (venceu) begin
          w_state_nxt = S_PISCA;
          w_res_nxt   = ADDR_VENCEU;
        end else if (iniciar) begin
          w_modo_nxt  = nivel;
        end
      end
      S_PISCA: begin
        // Last pair completes on the tick that ends an off phase.
        if (limpa) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick && r_phase && (r_pares == C_PAIR_LAST)) begin
          w_state_nxt = S_FIXO;
        end
      end
      S_FIXO: begin
        if (limpa) begin
          w_state_nxt = S_IDLE;
        end else if (iniciar) begin
          w_state_nxt = S_NIVEL;
          w_modo_nxt  = nivel;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_phase_nxt = 1'b0;
    w_pares_nxt = '0;
    if ((r_state == S_PISCA) && (w_state_nxt == S_PISCA)) begin
      w_phase_nxt = r_phase ^ w_tick;
      w_pares_nxt = (w_tick && r_phase) ? r_pares + 1'b1 : r_pares;
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_addr_nxt    = ADDR_APAGADO;
    w_ocupado_nxt = (w_state_nxt == S_PISCA);
    w_fim_nxt     = (w_state_nxt == S_FIXO) && (r_state == S_PISCA);
    case (w_state_nxt)
      S_IDLE:  w_addr_nxt = ADDR_APAGADO;
      S_NIVEL: w_addr_nxt = ADDR_NIVEL;
      S_PISCA: w_addr_nxt = w_phase_nxt ? ADDR_APAGADO : w_res_nxt;
      S_FIXO:  w_addr_nxt = w_res_nxt;
      default: w_addr_nxt = ADDR_APAGADO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr    <= ADDR_APAGADO;
      r_ocupado <= 1'b0;
      r_fim     <= 1'b0;
    end else begin
      r_addr    <= w_addr_nxt;
      r_ocupado <= w_ocupado_nxt;
      r_fim     <= w_fim_nxt;
    end
  end

  assign displayAddr = r_addr;
  assign modo        = r_modo;
  assign ocupado     = r_ocupado;
  assign fim_msg     = r_fim;

endmodule

`default_nettype wire

// File: tb/tb_display_ctrl.sv
// ============================================================================
// tb_display_ctrl : scoreboard bench for display_ctrl (directed + random)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_display_ctrl;

  localparam int BC = 4;
  localparam int NP = 2;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       iniciar = 1'b0;
  logic [1:0] nivel   = 2'b00;
  logic       venceu  = 1'b0;
  logic       perdeu  = 1'b0;
  logic       limpa   = 1'b0;
  logic [1:0] displayAddr;
  logic [1:0] modo;
  logic       ocupado;
  logic       fim_msg;

  display_ctrl #(
    .BLINK_CYCLES(BC),
    .NUM_PISCAS  (NP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .nivel      (nivel),
    .venceu     (venceu),
    .perdeu     (perdeu),
    .limpa      (limpa),
    .displayAddr(displayAddr),
    .modo       (modo),
    .ocupado    (ocupado),
    .fim_msg    (fim_msg)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] addr;
    logic [1:0] modo;
    logic       ocu;
    logic       fim;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: what message is on screen and how long a blink has run.
  // kind: 0 blank, 1 level, 2 blinking result, 3 steady result
  int         m_kind = 0;
  int         m_age  = 0;
  logic [1:0] m_res  = 2'b01;
  logic [1:0] m_modo = 2'b00;

  task automatic step(input logic r, input logic ini, input logic [1:0] nv,
                      input logic v, input logic p, input logic l);
    exp_t e;
    logic f;
    @(negedge clock);
    reset = r; iniciar = ini; nivel = nv; venceu = v; perdeu = p; limpa = l;
    f = 1'b0;
    if (r) begin
      m_kind = 0; m_modo = 2'b00; m_age = 0;
    end else begin
      case (m_kind)
        0: if (ini) begin m_kind = 1; m_modo = nv; end
        1: begin
          if (l)        m_kind = 0;
          else if (p)   begin m_kind = 2; m_res = 2'b10; m_age = 0; end
          else if (v)   begin m_kind = 2; m_res = 2'b01; m_age = 0; end
          else if (ini) m_modo = nv;
        end
        2: begin
          if (l) m_kind = 0;
          else begin
            m_age++;
            if (m_age == 2 * NP * BC) begin m_kind = 3; f = 1'b1; end
          end
        end
        default: begin
          if (l)        m_kind = 0;
          else if (ini) begin m_kind = 1; m_modo = nv; end
        end
      endcase
    end
    e.modo = m_modo;
    e.ocu  = (m_kind == 2);
    e.fim  = f;
    case (m_kind)
      0:       e.addr = 2'b11;
      1:       e.addr = 2'b00;
      2:       e.addr = (((m_age / BC) % 2) == 0) ? m_res : 2'b11;
      default: e.addr = m_res;
    endcase
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare just after the edge.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {displayAddr, modo, ocupado, fim_msg};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got addr=%b modo=%b ocupado=%b fim=%b expected addr=%b modo=%b ocupado=%b fim=%b",
                   $time, got.addr, got.modo, got.ocu, got.fim, e.addr, e.modo, e.ocu, e.fim);
        end
      end
    end
  end

  initial begin
    int budget;
    // Reset, then win pulse ignored in IDLE
    step(1, 0, 2'd0, 0, 0, 0);
    step(1, 0, 2'd0, 0, 0, 0);
    idle(1);
    step(0, 0, 2'd0, 1, 0, 0);
    idle(1);
    // Level latch and re-latch
    step(0, 1, 2'd2, 0, 0, 0);
    idle(1);
    step(0, 1, 2'd3, 0, 0, 0);
    idle(1);
    // Win blink to steady
    step(0, 0, 2'd0, 1, 0, 0);
    idle(20);
    // Back to level, simultaneous win+lose
    step(0, 1, 2'd0, 0, 0, 0);
    step(0, 0, 2'd0, 1, 1, 0);
    idle(20);
    // New level from steady lose, then lose again
    step(0, 1, 2'd1, 0, 0, 0);
    idle(1);
    step(0, 0, 2'd0, 0, 1, 0);
    idle(18);
    // Abort blink with limpa
    step(0, 1, 2'd2, 0, 0, 0);
    step(0, 0, 2'd0, 1, 0, 0);
    idle(5);
    step(0, 0, 2'd0, 0, 0, 1);
    idle(3);
    // Reset in the middle of a blink
    step(0, 1, 2'd3, 0, 0, 0);
    step(0, 0, 2'd0, 0, 1, 0);
    idle(4);
    step(1, 0, 2'd0, 0, 0, 0);
    idle(3);
    // Randomised events
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) < 2,
           $urandom_range(0, 99) < 10,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 7,
           $urandom_range(0, 99) < 4);
    end
    @(negedge clock);
    reset = 0; iniciar = 0; venceu = 0; perdeu = 0; limpa = 0;
    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
